noc_port_arbiter: RTL and testbench
===================================

NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of requesting router input ports (0=N,1=S,2=E,3=W,4=Local).
REQ-002 Parameter CREDITS, default 4, downstream buffer depth in flits; CW = $clog2(CREDITS+1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_PORTS  port i holds a valid flit for this output.
REQ-006 head  input  NUM_PORTS  flit at port i is a head flit; meaningful only with req[i].
REQ-007 tail  input  NUM_PORTS  flit at port i is a tail flit; head&tail means a single-flit packet.
REQ-008 credit_ret  input  1  downstream freed one buffer slot this cycle.
REQ-009 gnt  output  NUM_PORTS  one-hot or zero; port selected for this output.
REQ-010 xfer  output  1  a flit moves from the granted port to the output this cycle.
REQ-011 credits  output  CW  available downstream credits.
REQ-012 busy  output  1  high in LOCKED.
REQ-013 cred_err  output  1  sticky credit-overflow flag.

Function
REQ-014 FSM states: IDLE and LOCKED; registered owner index and round-robin pointer ptr.
REQ-015 IDLE: candidates = req & head; when candidates != 0 and credits > 0, gnt = first candidate searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_PORTS-1, 0, ...); otherwise gnt = 0.
REQ-016 gnt and xfer are combinational from current state and inputs; zero-cycle grant latency.
REQ-017 xfer = |(gnt & req) and credits > 0.
REQ-018 IDLE with xfer and the winner's tail = 0: next state LOCKED, owner = winner.
REQ-019 IDLE with xfer and the winner's tail = 1: stay IDLE; ptr = (winner+1) mod NUM_PORTS.
REQ-020 LOCKED: gnt = onehot(owner) regardless of req or credits; no other port is granted (wormhole lock).
REQ-021 LOCKED with xfer and tail[owner] = 1: next state IDLE; ptr = (owner+1) mod NUM_PORTS.
REQ-022 LOCKED with req[owner] = 0 or credits = 0: no xfer; hold state, owner, and ptr.
REQ-023 In LOCKED, head[owner] is ignored; a head flit does not restart arbitration.
REQ-024 Credit update: xfer only -> credits-1; credit_ret only -> credits+1; both -> unchanged; neither -> unchanged.
REQ-025 credit_ret without xfer while credits = CREDITS: credits stays CREDITS and cred_err is set to 1.
REQ-026 cred_err stays 1 until rst.
REQ-027 credits never underflows; xfer is impossible at credits = 0.
REQ-028 A request from a non-owner port in LOCKED waits with no side effects; it may win in the IDLE cycle after the tail transfers.

Reset
REQ-029 rst = 1 at a clock edge applies the following, overriding all other updates in that cycle including mid-packet (LOCKED):
- state = IDLE, owner = 0, ptr = 0
- credits = CREDITS
- cred_err = 0
REQ-030 While rst = 1, gnt = 0 and xfer = 0.

Verification
REQ-031 Reset, then req = 5'b10001 with head = tail = 5'b10001 held: xfer every cycle while credits > 0 (credit_ret = 0); grants alternate 0 -> 4 -> 0 -> 4; credits 4 -> 0; then gnt = 0.
REQ-032 Port 2 sends a 3-flit packet (head, body, tail) while port 1 requests a head flit throughout:
- gnt = 5'b00100 for 3 xfer cycles
- busy high after the head
- next cycle gnt = 5'b00010 (ptr = 3 wraps to port 1)
REQ-033 LOCKED on port 3 with credits = 0: req[3] held, no xfer, gnt stays 5'b01000; one credit_ret -> credits = 1 -> xfer next cycle.
REQ-034 Simultaneous xfer and credit_ret at credits = 2: credits stays 2. credit_ret at credits = 4 with no xfer: credits stays 4, cred_err = 1 and stays high.
REQ-035 rst asserted mid-packet in LOCKED: next cycle busy = 0, credits = 4, gnt = 0 during rst; after release, a head from port 0 is granted first.

Source files
------------

// File: rtl/noc_port_arbiter_if.sv
// Output-port arbitration bundle for one router output.
//   req/head/tail : per-input-port flit valid and framing (master -> slave)
//   credit_ret    : downstream freed one buffer slot (master -> slave)
//   gnt/xfer      : selected port and flit-move strobe (slave -> master)
//   credits/busy/cred_err : credit count, wormhole lock, sticky overflow
interface noc_port_arbiter_if #(
  parameter int NUM_PORTS = 5,
  parameter int CREDITS   = 4
);
  localparam int CW = $clog2(CREDITS + 1);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] head;
  logic [NUM_PORTS-1:0] tail;
  logic                 credit_ret;
  logic [NUM_PORTS-1:0] gnt;
  logic                 xfer;
  logic [CW-1:0]        credits;
  logic                 busy;
  logic                 cred_err;

  modport master (
    output req, head, tail, credit_ret,
    input  gnt, xfer, credits, busy, cred_err
  );

  modport slave (
    input  req, head, tail, credit_ret,
    output gnt, xfer, credits, busy, cred_err
  );
endinterface

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter with credit flow control for one router
// output port.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : noc_port_arbiter_if.slave (req/head/tail/credit_ret in,
//         gnt/xfer/credits/busy/cred_err out)
// In IDLE a head flit is picked round-robin starting at ptr; a packet
// without a single-flit tail locks the output to its owner until the
// tail moves. Grant and xfer are combinational (zero-cycle latency).

// Per-port candidate cell: head request, and whether it sits at or above
// the round-robin pointer (first search window before wrap).
module noc_arb_port_cell #(
  parameter int IDX = 0,
  parameter int PW  = 3
) (
  input  logic          req,
  input  logic          head,
  input  logic [PW-1:0] ptr,
  output logic          cand,
  output logic          cand_hi
);
  assign cand    = req & head;
  assign cand_hi = cand & (PW'(IDX) >= ptr);
endmodule

module noc_port_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int CREDITS   = 4
) (
  input  logic            clk,
  input  logic            rst,
  noc_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        owner, owner_n;
  logic [PW-1:0]        ptr, ptr_n;
  logic [CW-1:0]        cred, cred_n;
  logic                 err, err_n;

  logic [NUM_PORTS-1:0] req, head, tail;
  logic [NUM_PORTS-1:0] cand, cand_hi;
  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        hi_idx, lo_idx, win;
  logic                 have_cred, xfer, gnt_tail;

  assign req  = bus.req;
  assign head = bus.head;
  assign tail = bus.tail;

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    return (v == PW'(NUM_PORTS - 1)) ? '0 : v + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    noc_arb_port_cell #(.IDX(i), .PW(PW)) u_cell (
      .req     (req[i]),
      .head    (head[i]),
      .ptr     (ptr),
      .cand    (cand[i]),
      .cand_hi (cand_hi[i])
    );
  end

  // Lowest set index in each window; scanning downward leaves the lowest.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand_hi[i]) hi_idx = PW'(i);
      if (cand[i])    lo_idx = PW'(i);
    end
    win = (|cand_hi) ? hi_idx : lo_idx;
  end

  assign have_cred = (cred != '0);

  always_comb begin
    gnt = '0;
    case (state)
      IDLE:    if ((|cand) && have_cred) gnt = ONE << win;
      LOCKED:  gnt = ONE << owner;  // wormhole lock ignores credits/head
      default: gnt = '0;
    endcase
    if (rst) gnt = '0;
  end

  assign xfer     = (|(gnt & req)) && have_cred;
  assign gnt_tail = |(gnt & tail);

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    case (state)
      IDLE: if (xfer) begin
        if (gnt_tail) ptr_n = inc_wrap(win);
        else begin
          state_n = LOCKED;
          owner_n = win;
        end
      end
      LOCKED: if (xfer && gnt_tail) begin
        state_n = IDLE;
        ptr_n   = inc_wrap(owner);
      end
      default: state_n = IDLE;
    endcase
  end

  // Credits: a return while already full is dropped and flagged.
  always_comb begin
    cred_n = cred;
    err_n  = err;
    case ({xfer, bus.credit_ret})
      2'b10: cred_n = cred - 1'b1;
      2'b01: begin
        if (cred == CW'(CREDITS)) err_n = 1'b1;
        else                      cred_n = cred + 1'b1;
      end
      default: cred_n = cred;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cred  <= CW'(CREDITS);
      err   <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      cred  <= cred_n;
      err   <= err_n;
    end
  end

  assign bus.gnt      = gnt;
  assign bus.xfer     = xfer;
  assign bus.credits  = cred;
  assign bus.busy     = (state == LOCKED);
  assign bus.cred_err = err;
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: inputs change 1ns after the rising
// edge, outputs are sampled on the falling edge.
module tb_noc_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  noc_port_arbiter_if #(.NUM_PORTS(5), .CREDITS(4)) bus();

  noc_port_arbiter #(.NUM_PORTS(5), .CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] h,
                       input logic [4:0] t, input logic cr);
    bus.req = r;
    bus.head = h;
    bus.tail = t;
    bus.credit_ret = cr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1);
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.xfer} !== 6'b0) begin
      errors++;
      $display("FAIL reset_gnt got gnt=%b xfer=%b want 00000/0", bus.gnt, bus.xfer);
    end
    tick(); tick();
    @(negedge clk);
    checks++;
    if ({bus.credits, bus.busy, bus.cred_err} !== {3'd4, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got cred=%0d busy=%b err=%b want 4/0/0",
               bus.credits, bus.busy, bus.cred_err);
    end
    rst = 1'b0;
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    tick();
  endtask

  task automatic test_alternate();
    logic [4:0] eg [5];
    logic [2:0] ec [5];
    eg = '{5'b00001, 5'b10000, 5'b00001, 5'b10000, 5'b00000};
    ec = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    drive(5'b10001, 5'b10001, 5'b10001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== eg[k] || bus.xfer !== (k < 4) || bus.credits !== ec[k]) begin
        errors++;
        $display("FAIL alternate[%0d] got gnt=%b xfer=%b cred=%0d want %b/%b/%0d",
                 k, bus.gnt, bus.xfer, bus.credits, eg[k], (k < 4), ec[k]);
      end
      tick();
    end
  endtask

  task automatic test_wormhole();
    logic [4:0] er [5], eh [5], et [5], eg [5];
    logic       eb [5];
    // port 1 single-flit first (moves ptr to 2), then port 2 head/body/tail
    er = '{5'b00010, 5'b00110, 5'b00110, 5'b00110, 5'b00010};
    eh = '{5'b00010, 5'b00110, 5'b00010, 5'b00010, 5'b00010};
    et = '{5'b00010, 5'b00010, 5'b00010, 5'b00110, 5'b00010};
    eg = '{5'b00010, 5'b00100, 5'b00100, 5'b00100, 5'b00010};
    eb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(er[k], eh[k], et[k], 1'b1);
      @(negedge clk);
      checks++;
      if (bus.gnt !== eg[k] || bus.xfer !== 1'b1 || bus.busy !== eb[k] ||
          bus.credits !== 3'd4) begin
        errors++;
        $display("FAIL wormhole[%0d] got gnt=%b xfer=%b busy=%b cred=%0d want %b/1/%b/4",
                 k, bus.gnt, bus.xfer, bus.busy, bus.credits, eg[k], eb[k]);
      end
      tick();
    end
    drive(5'b0, 5'b0, 5'b0, 1'b0);
  endtask

  task automatic test_credit_stall();
    do_reset();
    drive(5'b01000, 5'b01000, 5'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 5'b01000 || bus.xfer !== 1'b1) begin
      errors++;
      $display("FAIL stall_head got gnt=%b xfer=%b want 01000/1", bus.gnt, bus.xfer);
    end
    tick();
    drive(5'b01000, 5'b0, 5'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 5'b01000 || bus.xfer !== 1'b1 || bus.busy !== 1'b1 ||
          bus.credits !== 3'(3 - k)) begin
        errors++;
        $display("FAIL stall_body[%0d] got gnt=%b xfer=%b busy=%b cred=%0d want 01000/1/1/%0d",
                 k, bus.gnt, bus.xfer, bus.busy, bus.credits, 3 - k);
      end
      tick();
    end
    // credits exhausted; owner head bit and a port-0 head must not disturb the lock
    drive(5'b01001, 5'b01001, 5'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 5'b01000 || bus.xfer !== 1'b0 || bus.busy !== 1'b1 ||
          bus.credits !== 3'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got gnt=%b xfer=%b busy=%b cred=%0d want 01000/0/1/0",
                 k, bus.gnt, bus.xfer, bus.busy, bus.credits);
      end
      tick();
    end
    drive(5'b01001, 5'b01001, 5'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.xfer !== 1'b0) begin
      errors++;
      $display("FAIL stall_ret got xfer=%b want 0", bus.xfer);
    end
    tick();
    drive(5'b01001, 5'b00001, 5'b01000, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 5'b01000 || bus.xfer !== 1'b1 || bus.credits !== 3'd1) begin
      errors++;
      $display("FAIL stall_resume got gnt=%b xfer=%b cred=%0d want 01000/1/1",
               bus.gnt, bus.xfer, bus.credits);
    end
    tick();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 5'b0 || bus.busy !== 1'b0 || bus.credits !== 3'd0) begin
      errors++;
      $display("FAIL stall_tail got gnt=%b busy=%b cred=%0d want 00000/0/0",
               bus.gnt, bus.busy, bus.credits);
    end
    tick();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 5'b00001 || bus.xfer !== 1'b1) begin
      errors++;
      $display("FAIL stall_waiter got gnt=%b xfer=%b want 00001/1", bus.gnt, bus.xfer);
    end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
  endtask

  task automatic test_credit_update();
    logic [2:0] ec [6];
    logic       ee [6];
    do_reset();
    drive(5'b00001, 5'b00001, 5'b00001, 1'b0);
    tick(); tick();
    // xfer+ret, ret, ret, ret at full, idle, idle
    ec = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    ee = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(5'b00001, 5'b00001, 5'b00001, 1'b1);
      else if (k < 4)  drive(5'b0, 5'b0, 5'b0, 1'b1);
      else             drive(5'b0, 5'b0, 5'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.credits !== ec[k] || bus.cred_err !== ee[k] || bus.xfer !== (k == 0)) begin
        errors++;
        $display("FAIL credit[%0d] got cred=%0d err=%b xfer=%b want %0d/%b/%b",
                 k, bus.credits, bus.cred_err, bus.xfer, ec[k], ee[k], (k == 0));
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cred_err !== 1'b0) begin
      errors++;
      $display("FAIL credit_err_clear got err=%b want 0", bus.cred_err);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(5'b00100, 5'b00100, 5'b0, 1'b0);
    tick();
    drive(5'b00100, 5'b0, 5'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.credits !== 3'd3) begin
      errors++;
      $display("FAIL mid_locked got busy=%b cred=%0d want 1/3", bus.busy, bus.credits);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 5'b0 || bus.xfer !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_gnt got gnt=%b xfer=%b want 00000/0", bus.gnt, bus.xfer);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.credits !== 3'd4 || bus.gnt !== 5'b0) begin
      errors++;
      $display("FAIL mid_rst_state got busy=%b cred=%0d gnt=%b want 0/4/00000",
               bus.busy, bus.credits, bus.gnt);
    end
    tick();
    rst = 1'b0;
    drive(5'b00101, 5'b00101, 5'b00101, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 5'b00001 || bus.xfer !== 1'b1) begin
      errors++;
      $display("FAIL mid_after got gnt=%b xfer=%b want 00001/1", bus.gnt, bus.xfer);
    end
    tick();
    drive(5'b0, 5'b0, 5'b0, 1'b0);
  endtask

  initial begin
    drive(5'b0, 5'b0, 5'b0, 1'b0);
    test_reset();
    test_alternate();
    test_wormhole();
    test_credit_stall();
    test_credit_update();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
